// File: rtl/tl_buffer_a64d64.sv
// Two-channel TileLink-UL register buffer: independent A and D FIFOs that break
// the ready/valid path between the 64-bit bus crossing and the width widget.

package tl_buffer_a64d64_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;
  localparam int unsigned SIZE_W = 4;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned SINK_W = 4;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [SINK_W-1:0] sink;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_d_t;
endpackage

// Circular FIFO with registered storage; ready depends only on occupancy.
module tl_buffer_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [CNT_W-1:0] count;
  logic             in_reset;
  logic             enq;
  logic             deq;

  // Explicit wrap keeps non-power-of-2 depths from skipping into unused slots.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    in_ready  = (count != FULL) && !in_reset;
    out_valid = (count != '0);
    out_bits  = mem[rp];
    enq       = in_valid && in_ready;
    deq       = out_valid && out_ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      in_reset <= 1'b1;
    end else begin
      in_reset <= 1'b0;
      if (enq) begin
        mem[wp] <= in_bits;
        wp      <= bump(wp);
      end
      if (deq) rp <= bump(rp);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (!enq && deq) count <= count - CNT_W'(1);
    end
  end
endmodule

module tl_buffer_a64d64
  import tl_buffer_a64d64_pkg::*;
#(
  parameter int unsigned DEPTH_A = 2,
  parameter int unsigned DEPTH_D = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_in_a_valid,
  output logic        auto_in_a_ready,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [3:0]  auto_in_a_bits_source,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  output logic        auto_out_a_valid,
  input  logic        auto_out_a_ready,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [3:0]  auto_out_a_bits_size,
  output logic [3:0]  auto_out_a_bits_source,
  output logic [31:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  input  logic        auto_out_d_valid,
  output logic        auto_out_d_ready,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [3:0]  auto_out_d_bits_size,
  input  logic [3:0]  auto_out_d_bits_source,
  input  logic [3:0]  auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt,
  output logic        auto_in_d_valid,
  input  logic        auto_in_d_ready,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [3:0]  auto_in_d_bits_source,
  output logic [3:0]  auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt
);
  tl_a_t a_in;
  tl_a_t a_out;
  tl_d_t d_in;
  tl_d_t d_out;

  assign a_in = '{auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                  auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                  auto_in_a_bits_data, auto_in_a_bits_corrupt};
  assign d_in = '{auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
                  auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
                  auto_out_d_bits_data, auto_out_d_bits_corrupt};

  tl_buffer_fifo #(.DEPTH(DEPTH_A), .WIDTH($bits(tl_a_t))) u_a (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (auto_in_a_valid),
    .in_ready  (auto_in_a_ready),
    .in_bits   (a_in),
    .out_valid (auto_out_a_valid),
    .out_ready (auto_out_a_ready),
    .out_bits  (a_out)
  );

  tl_buffer_fifo #(.DEPTH(DEPTH_D), .WIDTH($bits(tl_d_t))) u_d (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (auto_out_d_valid),
    .in_ready  (auto_out_d_ready),
    .in_bits   (d_in),
    .out_valid (auto_in_d_valid),
    .out_ready (auto_in_d_ready),
    .out_bits  (d_out)
  );

  assign auto_out_a_bits_opcode  = a_out.opcode;
  assign auto_out_a_bits_param   = a_out.param;
  assign auto_out_a_bits_size    = a_out.size;
  assign auto_out_a_bits_source  = a_out.source;
  assign auto_out_a_bits_address = a_out.address;
  assign auto_out_a_bits_mask    = a_out.mask;
  assign auto_out_a_bits_data    = a_out.data;
  assign auto_out_a_bits_corrupt = a_out.corrupt;

  assign auto_in_d_bits_opcode  = d_out.opcode;
  assign auto_in_d_bits_param   = d_out.param;
  assign auto_in_d_bits_size    = d_out.size;
  assign auto_in_d_bits_source  = d_out.source;
  assign auto_in_d_bits_sink    = d_out.sink;
  assign auto_in_d_bits_denied  = d_out.denied;
  assign auto_in_d_bits_data    = d_out.data;
  assign auto_in_d_bits_corrupt = d_out.corrupt;
endmodule

// File: tb/tb_tl_buffer_a64d64.sv
// Bench for tl_buffer_a64d64: directed scenarios plus random traffic, checked
// every cycle against queue-based models of both channels.
module tb_tl_buffer_a64d64;
  import tl_buffer_a64d64_pkg::*;

  localparam int unsigned DA = 2;
  localparam int unsigned DD = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic  a_in_valid = 1'b0, a_out_ready = 1'b0, d_in_valid = 1'b0, d_out_ready = 1'b0;
  tl_a_t ai = '0;
  tl_d_t di = '0;

  logic        a_in_ready, a_out_valid, d_in_ready, d_out_valid;
  logic [2:0]  ao_opcode, ao_param;
  logic [3:0]  ao_size, ao_source;
  logic [31:0] ao_address;
  logic [7:0]  ao_mask;
  logic [63:0] ao_data;
  logic        ao_corrupt;
  logic [2:0]  do_opcode;
  logic [1:0]  do_param;
  logic [3:0]  do_size, do_source, do_sink;
  logic        do_denied, do_corrupt;
  logic [63:0] do_data;
  tl_a_t a_obs;
  tl_d_t d_obs;

  assign a_obs = '{ao_opcode, ao_param, ao_size, ao_source, ao_address, ao_mask, ao_data, ao_corrupt};
  assign d_obs = '{do_opcode, do_param, do_size, do_source, do_sink, do_denied, do_data, do_corrupt};

  tl_buffer_a64d64 #(.DEPTH_A(DA), .DEPTH_D(DD)) dut (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(a_in_valid), .auto_in_a_ready(a_in_ready),
    .auto_in_a_bits_opcode(ai.opcode), .auto_in_a_bits_param(ai.param),
    .auto_in_a_bits_size(ai.size), .auto_in_a_bits_source(ai.source),
    .auto_in_a_bits_address(ai.address), .auto_in_a_bits_mask(ai.mask),
    .auto_in_a_bits_data(ai.data), .auto_in_a_bits_corrupt(ai.corrupt),
    .auto_out_a_valid(a_out_valid), .auto_out_a_ready(a_out_ready),
    .auto_out_a_bits_opcode(ao_opcode), .auto_out_a_bits_param(ao_param),
    .auto_out_a_bits_size(ao_size), .auto_out_a_bits_source(ao_source),
    .auto_out_a_bits_address(ao_address), .auto_out_a_bits_mask(ao_mask),
    .auto_out_a_bits_data(ao_data), .auto_out_a_bits_corrupt(ao_corrupt),
    .auto_out_d_valid(d_in_valid), .auto_out_d_ready(d_in_ready),
    .auto_out_d_bits_opcode(di.opcode), .auto_out_d_bits_param(di.param),
    .auto_out_d_bits_size(di.size), .auto_out_d_bits_source(di.source),
    .auto_out_d_bits_sink(di.sink), .auto_out_d_bits_denied(di.denied),
    .auto_out_d_bits_data(di.data), .auto_out_d_bits_corrupt(di.corrupt),
    .auto_in_d_valid(d_out_valid), .auto_in_d_ready(d_out_ready),
    .auto_in_d_bits_opcode(do_opcode), .auto_in_d_bits_param(do_param),
    .auto_in_d_bits_size(do_size), .auto_in_d_bits_source(do_source),
    .auto_in_d_bits_sink(do_sink), .auto_in_d_bits_denied(do_denied),
    .auto_in_d_bits_data(do_data), .auto_in_d_bits_corrupt(do_corrupt)
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  int    a_seen = 0;
  tl_a_t qa[$];
  tl_d_t qd[$];
  bit    m_rst = 1'b1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs to the model, then advance the model at the edge.
  task automatic step();
    bit ea, da, ed, dd;
    #1;
    if (!reset) begin
      m_rst = 1'b1;
      qa.delete();
      qd.delete();
    end
    check("a_ready", 128'(a_in_ready), 128'(!m_rst && qa.size() < DA));
    check("a_valid", 128'(a_out_valid), 128'(qa.size() != 0));
    check("d_ready", 128'(d_in_ready), 128'(!m_rst && qd.size() < DD));
    check("d_valid", 128'(d_out_valid), 128'(qd.size() != 0));
    if (qa.size() != 0) check("a_bits", 128'(a_obs), 128'(qa[0]));
    else if (m_rst) check("a_bits_rst", 128'(a_obs), 128'(0));
    if (qd.size() != 0) check("d_bits", 128'(d_obs), 128'(qd[0]));
    else if (m_rst) check("d_bits_rst", 128'(d_obs), 128'(0));
    if (a_out_valid && a_out_ready) a_seen++;
    ea = a_in_valid && !m_rst && qa.size() < DA;
    da = qa.size() != 0 && a_out_ready;
    ed = d_in_valid && !m_rst && qd.size() < DD;
    dd = qd.size() != 0 && d_out_ready;
    @(posedge clock);
    if (reset) begin
      if (da) void'(qa.pop_front());
      if (ea) qa.push_back(ai);
      if (dd) void'(qd.pop_front());
      if (ed) qd.push_back(di);
      m_rst = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic rand_payloads();
    logic [127:0] r;
    r  = {$urandom, $urandom, $urandom, $urandom};
    ai = tl_a_t'(r[$bits(tl_a_t)-1:0]);
    r  = {$urandom, $urandom, $urandom, $urandom};
    di = tl_d_t'(r[$bits(tl_d_t)-1:0]);
  endtask

  initial begin
    int start;
    @(negedge clock);

    // Reset held with A traffic offered; nothing may be captured.
    a_in_valid = 1'b1;
    ai = '{opcode:3'd0, param:3'd0, size:4'd3, source:4'd9, address:32'hdead_0000,
           mask:8'hff, data:64'hbad, corrupt:1'b0};
    repeat (3) step();
    reset = 1'b1;
    step();
    a_in_valid = 1'b0;
    step();

    // A streaming: 8 Put beats back-to-back, downstream always ready.
    a_out_ready = 1'b1;
    start = a_seen;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1;
      ai = '{opcode:3'd0, param:3'd0, size:4'd3, source:4'(i),
             address:32'h8000_0000 + 32'(8 * i), mask:8'hff, data:64'(i), corrupt:1'b0};
      step();
    end
    a_in_valid = 1'b0;
    step();
    check("a_stream_beats", 128'(a_seen - start), 128'(8));

    // A backpressure: only DEPTH_A beats accepted, then drain.
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      ai.data = 64'(100 + i);
      ai.source = 4'(i);
      step();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    repeat (3) step();

    // D: fill, then offer enqueue and dequeue together while full.
    d_out_ready = 1'b0;
    for (int i = 0; i < int'(DD); i++) begin
      d_in_valid = 1'b1;
      di = '{opcode:3'd1, param:2'd0, size:4'd3, source:4'(i), sink:4'd2,
             denied:1'(i), data:64'(200 + i), corrupt:1'b0};
      step();
    end
    di.source = 4'd7;
    di.data = 64'd777;
    d_out_ready = 1'b1;
    step();
    d_in_valid = 1'b0;
    repeat (4) step();

    // Random traffic on both channels exercises wrap on the depth-3 D FIFO.
    for (int i = 0; i < 400; i++) begin
      rand_payloads();
      a_in_valid  = 1'($urandom_range(0, 1));
      d_in_valid  = 1'($urandom_range(0, 1));
      a_out_ready = 1'($urandom_range(0, 1));
      d_out_ready = 1'($urandom_range(0, 1));
      step();
    end

    // Mid-burst reset: two A beats buffered, reset drops them asynchronously.
    a_in_valid = 1'b0;
    d_in_valid = 1'b0;
    a_out_ready = 1'b1;
    d_out_ready = 1'b1;
    repeat (4) step();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    rand_payloads();
    step();
    rand_payloads();
    step();
    a_in_valid = 1'b0;
    check("a_valid_before_rst", 128'(a_out_valid), 128'(1));
    reset = 1'b0;
    #1;
    check("a_valid_async_drop", 128'(a_out_valid), 128'(0));
    check("a_bits_async_clear", 128'(a_obs), 128'(0));
    step();
    reset = 1'b1;
    a_out_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
